// File: rtl/mips_pkg.sv
// mips_pkg -- shared definitions for the MEM pipeline stage.
//   MEM_READ_BIT / MEM_WRITE_BIT : bit positions inside MEMControl
//   DEFAULT_DEPTH_WORDS          : default data memory depth (32-bit words)
//   DEFAULT_WAIT_CYCLES          : default extra access cycles per memory op
//   mem_state_t                  : MEM stage FSM states
package mips_pkg;

    localparam int MEM_READ_BIT        = 1;
    localparam int MEM_WRITE_BIT       = 0;
    localparam int DEFAULT_DEPTH_WORDS = 256;
    localparam int DEFAULT_WAIT_CYCLES = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_t;

endpackage

// File: rtl/data_mem.sv
// data_mem -- word-addressed data storage, synchronous write, asynchronous read.
// Contents have no reset.
//   clk   in   rising-edge clock
//   we    in   write enable, word written at the rising edge
//   addr  in   word index (shared by read and write)
//   wdata in   write data
//   rdata out  combinational read of mem[addr]
module data_mem #(
    parameter int DEPTH_WORDS = 256,
    parameter int IW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [IW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage.sv
// mem_stage -- MEM pipeline stage with a multi-cycle data memory.
// Non-memory ops and misaligned memory ops complete in the cycle they arrive.
// Aligned loads/stores are captured, the stage stalls upstream for
// WAIT_CYCLES+1 cycles, then completes from the captured request.
//   clk, rst                 clock, async active-high reset
//   valid_in                 instruction present from EX/MEM latch
//   ALUResult_in             byte address or ALU result
//   WriteData_in             store data
//   WriteReg_in              destination register
//   WBControl_in             writeback control
//   MEMControl_in            [1] MemRead, [0] MemWrite
//   stall_out                upstream must hold its inputs
//   valid_out                result valid this cycle
//   ALUResult_out, ReadData_out, WriteReg_out, WBControl_out, misaligned_out
//                            result fields, all zero while valid_out=0
module mem_stage
    import mips_pkg::*;
#(
    parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [31:0] ALUResult_in,
    input  logic [31:0] WriteData_in,
    input  logic [4:0]  WriteReg_in,
    input  logic [1:0]  WBControl_in,
    input  logic [1:0]  MEMControl_in,
    output logic        stall_out,
    output logic        valid_out,
    output logic [31:0] ALUResult_out,
    output logic [31:0] ReadData_out,
    output logic [4:0]  WriteReg_out,
    output logic [1:0]  WBControl_out,
    output logic        misaligned_out
);

    localparam int CW = ($clog2(WAIT_CYCLES + 1) > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    mem_state_t  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0] req_addr_q,  req_addr_d;
    logic [31:0] req_wdata_q, req_wdata_d;
    logic [4:0]  req_wreg_q,  req_wreg_d;
    logic [1:0]  req_wb_q,    req_wb_d;
    logic        req_store_q, req_store_d;

    logic        mem_we;
    logic [31:0] mem_rdata;
    logic        in_is_mem;
    logic        in_is_store;

    assign in_is_mem   = MEMControl_in[MEM_READ_BIT] | MEMControl_in[MEM_WRITE_BIT];
    // MemRead+MemWrite together is a store
    assign in_is_store = MEMControl_in[MEM_WRITE_BIT];

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        req_addr_d     = req_addr_q;
        req_wdata_d    = req_wdata_q;
        req_wreg_d     = req_wreg_q;
        req_wb_d       = req_wb_q;
        req_store_d    = req_store_q;
        stall_out      = 1'b0;
        valid_out      = 1'b0;
        ALUResult_out  = '0;
        ReadData_out   = '0;
        WriteReg_out   = '0;
        WBControl_out  = '0;
        misaligned_out = 1'b0;
        mem_we         = 1'b0;

        case (state_q)
            IDLE: begin
                if (valid_in) begin
                    if (!in_is_mem) begin
                        valid_out     = 1'b1;
                        ALUResult_out = ALUResult_in;
                        WriteReg_out  = WriteReg_in;
                        WBControl_out = WBControl_in;
                    end else if (ALUResult_in[1:0] != 2'b00) begin
                        // no access; writeback suppressed so the result is harmless
                        valid_out      = 1'b1;
                        misaligned_out = 1'b1;
                        ALUResult_out  = ALUResult_in;
                        WriteReg_out   = WriteReg_in;
                    end else begin
                        stall_out   = 1'b1;
                        state_d     = BUSY;
                        cnt_d       = CW'(WAIT_CYCLES);
                        req_addr_d  = ALUResult_in;
                        req_wdata_d = WriteData_in;
                        req_wreg_d  = WriteReg_in;
                        req_wb_d    = WBControl_in;
                        req_store_d = in_is_store;
                    end
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    stall_out = 1'b1;
                    cnt_d     = cnt_q - CW'(1);
                end else begin
                    // completion cycle; store lands on the edge that ends it
                    valid_out     = 1'b1;
                    ALUResult_out = req_addr_q;
                    WriteReg_out  = req_wreg_q;
                    WBControl_out = req_wb_q;
                    ReadData_out  = req_store_q ? 32'h0 : mem_rdata;
                    mem_we        = req_store_q;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // reset is asynchronous; the outputs must go quiet immediately and a
        // pending store must not reach memory on an edge seen during reset
        if (rst) begin
            stall_out      = 1'b0;
            valid_out      = 1'b0;
            ALUResult_out  = '0;
            ReadData_out   = '0;
            WriteReg_out   = '0;
            WBControl_out  = '0;
            misaligned_out = 1'b0;
            mem_we         = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_wreg_q  <= '0;
            req_wb_q    <= '0;
            req_store_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            req_wreg_q  <= req_wreg_d;
            req_wb_q    <= req_wb_d;
            req_store_q <= req_store_d;
        end
    end

    // upper address bits ignored: index wraps around the array
    data_mem #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .IW         (IW)
    ) u_data_mem (
        .clk  (clk),
        .we   (mem_we),
        .addr (req_addr_q[IW+1:2]),
        .wdata(req_wdata_q),
        .rdata(mem_rdata)
    );

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage -- directed self-checking bench for mem_stage (default params).
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic        valid_in;
    logic [31:0] ALUResult_in;
    logic [31:0] WriteData_in;
    logic [4:0]  WriteReg_in;
    logic [1:0]  WBControl_in;
    logic [1:0]  MEMControl_in;
    logic        stall_out;
    logic        valid_out;
    logic [31:0] ALUResult_out;
    logic [31:0] ReadData_out;
    logic [4:0]  WriteReg_out;
    logic [1:0]  WBControl_out;
    logic        misaligned_out;

    int checks = 0;
    int errors = 0;

    mem_stage dut (
        .clk           (clk),
        .rst           (rst),
        .valid_in      (valid_in),
        .ALUResult_in  (ALUResult_in),
        .WriteData_in  (WriteData_in),
        .WriteReg_in   (WriteReg_in),
        .WBControl_in  (WBControl_in),
        .MEMControl_in (MEMControl_in),
        .stall_out     (stall_out),
        .valid_out     (valid_out),
        .ALUResult_out (ALUResult_out),
        .ReadData_out  (ReadData_out),
        .WriteReg_out  (WriteReg_out),
        .WBControl_out (WBControl_out),
        .misaligned_out(misaligned_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] ctl, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [4:0] wr, input logic [1:0] wb);
        valid_in      = v;
        MEMControl_in = ctl;
        ALUResult_in  = addr;
        WriteData_in  = wd;
        WriteReg_in   = wr;
        WBControl_in  = wb;
    endtask

    // Drives a memory op right after an edge, counts stall cycles (bounded),
    // samples the completion cycle, then drops valid_in after the next edge.
    task automatic mem_op(input logic [1:0] ctl, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [4:0] wr, input logic [1:0] wb,
                          output int stalls, output logic v, output logic [31:0] rd,
                          output logic [4:0] wr_o, output logic [1:0] wb_o);
        drive(1'b1, ctl, addr, wd, wr, wb);
        #1;
        stalls = 0;
        while (stall_out && stalls < 10) begin
            stalls++;
            @(posedge clk);
            #2;
        end
        v    = valid_out;
        rd   = ReadData_out;
        wr_o = WriteReg_out;
        wb_o = WBControl_out;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
    endtask

    initial begin
        int          st;
        logic        v;
        logic [31:0] rd;
        logic [4:0]  wro;
        logic [1:0]  wbo;

        // reset with a pending load on the inputs
        rst = 1'b1;
        drive(1'b1, 2'b10, 32'h10, 32'h0, 5'd3, 2'b01);
        #2;
        chk("rst_stall", 32'(stall_out), 32'h0);
        chk("rst_valid", 32'(valid_out), 32'h0);
        chk("rst_alu", ALUResult_out, 32'h0);
        chk("rst_rd", ReadData_out, 32'h0);
        chk("rst_wreg", 32'(WriteReg_out), 32'h0);
        chk("rst_wb", 32'(WBControl_out), 32'h0);
        chk("rst_mis", 32'(misaligned_out), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        valid_in = 1'b0;
        #1;
        chk("idle_valid", 32'(valid_out), 32'h0);
        chk("idle_stall", 32'(stall_out), 32'h0);

        // store then load at 0x10
        mem_op(2'b01, 32'h10, 32'hDEADBEEF, 5'd4, 2'b00, st, v, rd, wro, wbo);
        chk("st10_stalls", 32'(st), 32'd3);
        chk("st10_valid", 32'(v), 32'h1);
        chk("st10_rd", rd, 32'h0);
        chk("post_st_valid", 32'(valid_out), 32'h0);
        mem_op(2'b10, 32'h10, 32'h0, 5'd7, 2'b11, st, v, rd, wro, wbo);
        chk("ld10_stalls", 32'(st), 32'd3);
        chk("ld10_valid", 32'(v), 32'h1);
        chk("ld10_rd", rd, 32'hDEADBEEF);
        chk("ld10_wreg", 32'(wro), 32'd7);
        chk("ld10_wb", 32'(wbo), 32'h3);

        // non-memory op completes in the same cycle
        drive(1'b1, 2'b00, 32'h12345678, 32'hFFFF0000, 5'h1F, 2'b10);
        #1;
        chk("alu_valid", 32'(valid_out), 32'h1);
        chk("alu_stall", 32'(stall_out), 32'h0);
        chk("alu_res", ALUResult_out, 32'h12345678);
        chk("alu_wreg", 32'(WriteReg_out), 32'h1F);
        chk("alu_wb", 32'(WBControl_out), 32'h2);
        chk("alu_rd", ReadData_out, 32'h0);
        chk("alu_mis", 32'(misaligned_out), 32'h0);
        @(posedge clk);
        #1;

        // misaligned load
        drive(1'b1, 2'b10, 32'h13, 32'h0, 5'd5, 2'b11);
        #1;
        chk("mis_flag", 32'(misaligned_out), 32'h1);
        chk("mis_valid", 32'(valid_out), 32'h1);
        chk("mis_wb", 32'(WBControl_out), 32'h0);
        chk("mis_rd", ReadData_out, 32'h0);
        chk("mis_stall", 32'(stall_out), 32'h0);
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        #1;
        chk("mis_no_busy", 32'(stall_out), 32'h0);
        @(posedge clk);
        #1;

        // a store killed by reset in its first BUSY cycle leaves memory intact
        mem_op(2'b01, 32'h20, 32'h11111111, 5'd1, 2'b00, st, v, rd, wro, wbo);
        chk("st20_stalls", 32'(st), 32'd3);
        drive(1'b1, 2'b01, 32'h20, 32'h22222222, 5'd1, 2'b00);
        #1;
        chk("st20b_stall_n", 32'(stall_out), 32'h1);
        @(posedge clk);
        #1;
        // BUSY now: inputs presented here must be ignored
        drive(1'b1, 2'b00, 32'hABCDEF00, 32'h0, 5'd9, 2'b01);
        #1;
        chk("busy_ignore_valid", 32'(valid_out), 32'h0);
        chk("busy_stall", 32'(stall_out), 32'h1);
        drive(1'b1, 2'b01, 32'h20, 32'h22222222, 5'd1, 2'b00);
        rst = 1'b1;
        #1;
        chk("rst_busy_stall", 32'(stall_out), 32'h0);
        chk("rst_busy_valid", 32'(valid_out), 32'h0);
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        valid_in = 1'b0;
        mem_op(2'b10, 32'h20, 32'h0, 5'd2, 2'b01, st, v, rd, wro, wbo);
        chk("ld20_rd", rd, 32'h11111111);
        chk("ld20_valid", 32'(v), 32'h1);

        // wrap-around: 0x410 maps to the same word as 0x10
        mem_op(2'b01, 32'h410, 32'hCAFEF00D, 5'd0, 2'b00, st, v, rd, wro, wbo);
        mem_op(2'b10, 32'h10, 32'h0, 5'd6, 2'b01, st, v, rd, wro, wbo);
        chk("wrap_rd", rd, 32'hCAFEF00D);
        chk("wrap_stalls", 32'(st), 32'd3);

        // MemRead+MemWrite behaves as a store
        mem_op(2'b11, 32'h30, 32'h55AA55AA, 5'd8, 2'b01, st, v, rd, wro, wbo);
        chk("both_rd", rd, 32'h0);
        chk("both_stalls", 32'(st), 32'd3);
        mem_op(2'b10, 32'h30, 32'h0, 5'd8, 2'b01, st, v, rd, wro, wbo);
        chk("both_ld_rd", rd, 32'h55AA55AA);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The block SHALL have parameters: DEPTH_WORDS, default 256, data memory depth in 32-bit words; WAIT_CYCLES, default 2, extra access cycles per memory operation.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset; ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-high reset
valid_in  in  1  instruction present from EX/MEM latch
ALUResult_in  in  32  byte address or ALU result
WriteData_in  in  32  store data
WriteReg_in  in  5  destination register
WBControl_in  in  2  writeback control, passed through
MEMControl_in  in  2  bit1 MemRead, bit0 MemWrite
stall_out  out  1  upstream must hold inputs stable
valid_out  out  1  result valid this cycle, to mem_wb_latch
ALUResult_out  out  32  forwarded ALU result
ReadData_out  out  32  load data
WriteReg_out  out  5  forwarded destination
WBControl_out  out  2  forwarded or suppressed writeback control
misaligned_out  out  1  memory op address not word-aligned

Function
REQ-003 FSM states SHALL be IDLE and BUSY, with a wait counter of width clog2(WAIT_CYCLES+1), minimum 1.
REQ-004 While valid_out=0, ALUResult_out, ReadData_out, WriteReg_out, WBControl_out and misaligned_out SHALL be 0.
REQ-005 Non-memory op (valid_in=1, MEMControl_in=00) in IDLE: same-cycle completion, valid_out=1, stall_out=0, inputs forwarded, ReadData_out=0.
REQ-006 Aligned memory op (address bits[1:0]=00) accepted in IDLE in cycle N: capture request, load counter with WAIT_CYCLES, enter BUSY; stall_out=1 in cycles N..N+WAIT_CYCLES.
REQ-007 In BUSY, counter decrements each cycle; completion cycle is N+WAIT_CYCLES+1, with stall_out=0, valid_out=1, outputs from captured request; return to IDLE at the next edge.
REQ-008 Store: memory word written at the rising edge ending the completion cycle; ReadData_out=0.
REQ-009 Load: ReadData_out = memory word during the completion cycle.
REQ-010 MemRead and MemWrite both set SHALL be treated as a store.
REQ-011 Word index SHALL be address bits [clog2(DEPTH_WORDS)+1:2]; higher bits ignored, giving wrap-around.
REQ-012 Misaligned memory op: no memory access, same-cycle completion, valid_out=1, misaligned_out=1, ReadData_out=0, WBControl_out=00, stall_out=0.
REQ-013 WAIT_CYCLES=0: memory op stalls cycle N only and completes in N+1.
REQ-014 Inputs arriving in BUSY SHALL be ignored; no new request is accepted until IDLE.
REQ-015 valid_in=0 in IDLE: no state change, stall_out=0, valid_out=0.

Reset
REQ-016 rst high SHALL force IDLE and counter=0 asynchronously; stall_out=0 and valid_out=0 while rst=1.
REQ-017 Reset during BUSY SHALL discard the pending op; a pending store SHALL NOT write memory.
REQ-018 Memory contents SHALL NOT be cleared by reset; contents are undefined until written.

Structure
REQ-019 Shared package mips_pkg SHALL hold MEMControl bit positions (MEM_READ_BIT=1, MEM_WRITE_BIT=0) and the default DEPTH_WORDS and WAIT_CYCLES values.
REQ-020 The storage array SHALL be a sub-module data_mem: synchronous write, asynchronous read, parameterised depth.
REQ-021 The FSM, counter and request capture registers SHALL reside in mem_stage.

Verification
REQ-022 Reset: rst=1, valid_in=1, MEMControl_in=10 -> stall_out=0, valid_out=0, all data outputs 0.
REQ-023 Store 0xDEADBEEF to address 0x10, then load 0x10 -> each op has stall_out high 3 cycles; load completion shows ReadData_out=0xDEADBEEF, valid_out=1.
REQ-024 Non-memory op: ALUResult_in=0x12345678, WriteReg_in=0x1F, WBControl_in=10 -> same cycle: valid_out=1, outputs equal inputs, ReadData_out=0, stall_out=0.
REQ-025 Load from 0x13 -> same cycle: misaligned_out=1, WBControl_out=00, ReadData_out=0, no stall.
REQ-026 Store 0x11111111 to 0x20; start store 0x22222222 to 0x20 and assert rst in the first BUSY cycle; then load 0x20 -> ReadData_out=0x11111111.
REQ-027 Store 0xCAFEF00D to 0x410; load 0x10 -> ReadData_out=0xCAFEF00D (wrap, DEPTH_WORDS=256).
